residual_rd_ctrl: RTL and testbench

Read-side controller for the inter residual out_ram. For each inter MB it reads the 24 residual 4x4 blocks (16 luma, 4 Cb, 4 Cr) in write order and presents each one to the inter reconstruction adder. Per block it runs a valid/ready handshake and never reads an address the writer has not yet filled. It sits between the residual write path, which supplies the write count, and the inter sum/recon stage.

---
 rtl/residual_rd_ctrl_pkg.sv | 35 +++
 rtl/residual_rd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_residual_rd_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/residual_rd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// residual_rd_ctrl_pkg
// Shared constants and types for the inter residual read controller.
//   BLK_NUM       : residual 4x4 blocks per MB (16 luma + 4 Cb + 4 Cr); this
//                   is also the terminal value of the read counter
//   AW            : out_ram address width
//   CHROMA_START  : first chroma block index (Cb)
//   CR_START      : first Cr block index
//   rd_state_t    : 3-bit FSM state encoding
// ---------------------------------------------------------------------------
package residual_rd_ctrl_pkg;

  localparam int BLK_NUM      = 24;
  localparam int AW           = 5;
  localparam int CHROMA_START = 16;
  localparam int CR_START     = 20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RD   = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } rd_state_t;

  // Block class helpers, used when a block index is registered for output.
  function automatic logic idx_is_chroma(input logic [AW-1:0] idx);
    return idx >= AW'(CHROMA_START);
  endfunction

  function automatic logic idx_is_cr(input logic [AW-1:0] idx);
    return idx >= AW'(CR_START);
  endfunction

endpackage

// File: rtl/residual_rd_ctrl.sv
// ---------------------------------------------------------------------------
// residual_rd_ctrl
// Read-side controller for the inter residual out_ram. For each inter MB it
// reads the 24 residual blocks in write order, one at a time, and presents
// each to the inter reconstruction adder. A block is only read once the
// writer's fill count is past it, and only one block is ever outstanding.
//
// Optional feature macro: RESIDUAL_RD_SKIP_EN
//   When defined, adds input mb_skip and output res_zero. A skip MB walks all
//   24 blocks without touching the RAM and flags each block as all-zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  global enable; when low every register holds
//   start_of_MB          one-cycle MB start pulse (aborts an MB in flight)
//   mb_pred_inter_sel    current MB is inter
//   out_ram_wr_addr      writer fill count for this MB
//   pred_valid           inter prediction for the next block is available
//   recon_ready          recon stage accepts the presented block
//   out_ram_rd           one-cycle RAM read strobe
//   out_ram_rd_addr      RAM read address / blocks-issued counter
//   res_valid            RAM data for blk_idx is valid
//   blk_idx              index of the presented block
//   blk_is_chroma        blk_idx >= 16
//   blk_is_cr            blk_idx >= 20
//   mb_rd_done           one-cycle pulse after the last block is accepted
//   mb_skip   (opt)      current MB is a skip MB
//   res_zero  (opt)      presented block is an implicit all-zero residual
//   fsm_state            debug view of the controller state (rd_state_t)
//
// Handshake: a block transfers on a rising edge where res_valid && recon_ready.
// res_valid, once raised, holds with a stable blk_idx until that transfer (or
// an MB abort); recon_ready while res_valid is low has no effect.
// ---------------------------------------------------------------------------
module residual_rd_ctrl
  import residual_rd_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start_of_MB,
  input  logic          mb_pred_inter_sel,
  input  logic [AW-1:0] out_ram_wr_addr,
  input  logic          pred_valid,
  input  logic          recon_ready,
`ifdef RESIDUAL_RD_SKIP_EN
  input  logic          mb_skip,
  output logic          res_zero,
`endif
  output logic          out_ram_rd,
  output logic [AW-1:0] out_ram_rd_addr,
  output logic          res_valid,
  output logic [AW-1:0] blk_idx,
  output logic          blk_is_chroma,
  output logic          blk_is_cr,
  output logic          mb_rd_done,
  output logic [2:0]    fsm_state
);

  rd_state_t state;
  logic      rd_ok;
  logic      mb_begin;

`ifdef RESIDUAL_RD_SKIP_EN
  logic skip_mb;
`endif

  assign fsm_state = state;

  // A start pulse restarts the controller from any busy state; in IDLE only
  // an inter MB starts it (an intra MB leaves it parked).
  assign mb_begin = start_of_MB && ((state != ST_IDLE) || mb_pred_inter_sel);

  // Next block may be read once the writer has filled past the read pointer
  // and prediction is ready. Plain 5-bit unsigned compare: the fill count
  // never exceeds BLK_NUM, so no wrap handling is needed.
  always_comb begin
    rd_ok = pred_valid && (out_ram_wr_addr > out_ram_rd_addr);
`ifdef RESIDUAL_RD_SKIP_EN
    // Skip MBs carry no RAM data, so only prediction gates progress.
    if (skip_mb) rd_ok = pred_valid;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      out_ram_rd      <= 1'b0;
      out_ram_rd_addr <= '0;
      res_valid       <= 1'b0;
      blk_idx         <= '0;
      blk_is_chroma   <= 1'b0;
      blk_is_cr       <= 1'b0;
      mb_rd_done      <= 1'b0;
`ifdef RESIDUAL_RD_SKIP_EN
      skip_mb         <= 1'b0;
      res_zero        <= 1'b0;
`endif
    end else if (ena) begin
      // Strobes are single-cycle unless re-asserted below.
      out_ram_rd <= 1'b0;
      mb_rd_done <= 1'b0;

`ifdef RESIDUAL_RD_SKIP_EN
      // The zero flag survives until a start that is not a skip MB.
      if (start_of_MB && !(mb_pred_inter_sel && mb_skip)) res_zero <= 1'b0;
`endif

      if (mb_begin) begin
        // Start/abort wins over every other transition this cycle.
        res_valid       <= 1'b0;
        out_ram_rd_addr <= '0;
        state           <= mb_pred_inter_sel ? ST_WAIT : ST_IDLE;
`ifdef RESIDUAL_RD_SKIP_EN
        skip_mb         <= mb_pred_inter_sel && mb_skip;
`endif
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end

          ST_WAIT: begin
            if (rd_ok) begin
              state      <= ST_RD;
`ifdef RESIDUAL_RD_SKIP_EN
              out_ram_rd <= !skip_mb;
`else
              out_ram_rd <= 1'b1;
`endif
            end
          end

          // out_ram_rd is high during this state with the current address;
          // RAM data lands one cycle later, together with res_valid.
          ST_RD: begin
            blk_idx         <= out_ram_rd_addr;
            blk_is_chroma   <= idx_is_chroma(out_ram_rd_addr);
            blk_is_cr       <= idx_is_cr(out_ram_rd_addr);
            out_ram_rd_addr <= out_ram_rd_addr + AW'(1);
            res_valid       <= 1'b1;
`ifdef RESIDUAL_RD_SKIP_EN
            if (skip_mb) res_zero <= 1'b1;
`endif
            state           <= ST_OUT;
          end

          ST_OUT: begin
            if (res_valid && recon_ready) begin
              res_valid <= 1'b0;
              // The counter already points past the presented block, so
              // reaching BLK_NUM means the last block just transferred.
              if (out_ram_rd_addr == AW'(BLK_NUM)) begin
                state      <= ST_DONE;
                mb_rd_done <= 1'b1;
              end else begin
                state <= ST_WAIT;
              end
            end
          end

          // Read pointer is left at BLK_NUM until the next MB start.
          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_residual_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_residual_rd_ctrl
// Self-checking bench for residual_rd_ctrl. Directed scenarios check exact
// cycle timing; randomized MBs are checked against a transaction-level model
// (expected block order queue, fill-count rule, one-outstanding rule).
// Define RESIDUAL_RD_SKIP_EN for both DUT and bench to cover skip MBs.
// ---------------------------------------------------------------------------
module tb_residual_rd_ctrl;
  import residual_rd_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ena;
  logic       start_of_MB;
  logic       mb_pred_inter_sel;
  logic [4:0] out_ram_wr_addr;
  logic       pred_valid;
  logic       recon_ready;
  logic       out_ram_rd;
  logic [4:0] out_ram_rd_addr;
  logic       res_valid;
  logic [4:0] blk_idx;
  logic       blk_is_chroma;
  logic       blk_is_cr;
  logic       mb_rd_done;
  logic [2:0] fsm_state;
`ifdef RESIDUAL_RD_SKIP_EN
  logic       mb_skip;
  logic       res_zero;
`endif

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  residual_rd_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ena               (ena),
    .start_of_MB       (start_of_MB),
    .mb_pred_inter_sel (mb_pred_inter_sel),
    .out_ram_wr_addr   (out_ram_wr_addr),
    .pred_valid        (pred_valid),
    .recon_ready       (recon_ready),
`ifdef RESIDUAL_RD_SKIP_EN
    .mb_skip           (mb_skip),
    .res_zero          (res_zero),
`endif
    .out_ram_rd        (out_ram_rd),
    .out_ram_rd_addr   (out_ram_rd_addr),
    .res_valid         (res_valid),
    .blk_idx           (blk_idx),
    .blk_is_chroma     (blk_is_chroma),
    .blk_is_cr         (blk_is_cr),
    .mb_rd_done        (mb_rd_done),
    .fsm_state         (fsm_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ena               = 1'b1;
    start_of_MB       = 1'b0;
    mb_pred_inter_sel = 1'b0;
    out_ram_wr_addr   = 5'd0;
    pred_valid        = 1'b0;
    recon_ready       = 1'b0;
`ifdef RESIDUAL_RD_SKIP_EN
    mb_skip           = 1'b0;
`endif
  endtask

  task automatic start_mb(input bit inter, input bit skip);
    start_of_MB       = 1'b1;
    mb_pred_inter_sel = inter;
`ifdef RESIDUAL_RD_SKIP_EN
    mb_skip           = skip;
`else
    if (skip) $display("note: skip request ignored without skip feature");
`endif
    tick;
    start_of_MB = 1'b0;
`ifdef RESIDUAL_RD_SKIP_EN
    mb_skip     = 1'b0;
`endif
  endtask

  // One block with pred_valid=1, recon_ready=1 and the block already filled:
  // WAIT -> RD -> OUT, three cycles.
  task automatic step_block_exact(input int k);
    logic [4:0] kk;
    kk = 5'(k);
    tick;
    checks++; if (out_ram_rd !== 1'b1) begin failures++; $display("FAIL blk_rd k=%0d got=%0b exp=1", k, out_ram_rd); end
    checks++; if (out_ram_rd_addr !== kk) begin failures++; $display("FAIL blk_rd_addr got=%0d exp=%0d", out_ram_rd_addr, kk); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL blk_rv_early k=%0d got=%0b exp=0", k, res_valid); end
    tick;
    checks++; if (out_ram_rd !== 1'b0) begin failures++; $display("FAIL blk_rd_len k=%0d got=%0b exp=0", k, out_ram_rd); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL blk_rv k=%0d got=%0b exp=1", k, res_valid); end
    checks++; if (blk_idx !== kk) begin failures++; $display("FAIL blk_idx got=%0d exp=%0d", blk_idx, kk); end
    checks++; if (blk_is_chroma !== (k >= 16)) begin failures++; $display("FAIL blk_chroma k=%0d got=%0b exp=%0b", k, blk_is_chroma, (k >= 16)); end
    checks++; if (blk_is_cr !== (k >= 20)) begin failures++; $display("FAIL blk_cr k=%0d got=%0b exp=%0b", k, blk_is_cr, (k >= 20)); end
    checks++; if (out_ram_rd_addr !== kk + 5'd1) begin failures++; $display("FAIL blk_addr_inc got=%0d exp=%0d", out_ram_rd_addr, kk + 5'd1); end
    tick;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL blk_rv_clr k=%0d got=%0b exp=0", k, res_valid); end
    checks++; if (mb_rd_done !== (k == 23)) begin failures++; $display("FAIL blk_done k=%0d got=%0b exp=%0b", k, mb_rd_done, (k == 23)); end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle;
    repeat (3) tick;
    checks++; if ({out_ram_rd, out_ram_rd_addr, res_valid, blk_idx, blk_is_chroma, blk_is_cr, mb_rd_done} !== 15'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {out_ram_rd, out_ram_rd_addr, res_valid, blk_idx, blk_is_chroma, blk_is_cr, mb_rd_done});
    end
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
`ifdef RESIDUAL_RD_SKIP_EN
    checks++; if (res_zero !== 1'b0) begin failures++; $display("FAIL reset_res_zero got=%0b exp=0", res_zero); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_full_mb;
    drive_idle;
    out_ram_wr_addr = 5'd24;
    pred_valid      = 1'b1;
    recon_ready     = 1'b1;
    start_mb(1'b1, 1'b0);
    checks++; if (fsm_state !== ST_WAIT) begin failures++; $display("FAIL full_start_state got=%0d exp=%0d", fsm_state, ST_WAIT); end
    checks++; if (out_ram_rd_addr !== 5'd0) begin failures++; $display("FAIL full_start_addr got=%0d exp=0", out_ram_rd_addr); end
    for (int k = 0; k < 24; k++) step_block_exact(k);
    tick;
    checks++; if (mb_rd_done !== 1'b0) begin failures++; $display("FAIL full_done_len got=%0b exp=0", mb_rd_done); end
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL full_end_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    checks++; if (out_ram_rd_addr !== 5'd24) begin failures++; $display("FAIL full_end_addr got=%0d exp=24", out_ram_rd_addr); end
  endtask

  task automatic test_writer_throttle;
    logic [4:0] rd_log[$];
    drive_idle;
    out_ram_wr_addr = 5'd3;
    pred_valid      = 1'b1;
    recon_ready     = 1'b1;
    start_mb(1'b1, 1'b0);
    for (int c = 0; c < 30; c++) begin
      tick;
      if (out_ram_rd === 1'b1) rd_log.push_back(out_ram_rd_addr);
    end
    checks++; if (rd_log.size() != 3) begin failures++; $display("FAIL thr_read_count got=%0d exp=3", rd_log.size()); end
    for (int i = 0; i < rd_log.size() && i < 3; i++) begin
      checks++; if (rd_log[i] !== 5'(i)) begin failures++; $display("FAIL thr_read_order got=%0d exp=%0d", rd_log[i], i); end
    end
    checks++; if (fsm_state !== ST_WAIT) begin failures++; $display("FAIL thr_wait_state got=%0d exp=%0d", fsm_state, ST_WAIT); end
    checks++; if (out_ram_rd_addr !== 5'd3) begin failures++; $display("FAIL thr_wait_addr got=%0d exp=3", out_ram_rd_addr); end
    out_ram_wr_addr = 5'd4;
    tick;
    checks++; if (out_ram_rd !== 1'b1 || out_ram_rd_addr !== 5'd3) begin
      failures++; $display("FAIL thr_resume got=rd%0b/addr%0d exp=rd1/addr3", out_ram_rd, out_ram_rd_addr);
    end
    tick;
    tick;
    out_ram_wr_addr = 5'd24;
    for (int k = 4; k < 24; k++) step_block_exact(k);
    tick;
  endtask

  task automatic test_backpressure;
    drive_idle;
    out_ram_wr_addr = 5'd24;
    pred_valid      = 1'b1;
    recon_ready     = 1'b1;
    start_mb(1'b1, 1'b0);
    for (int k = 0; k < 17; k++) step_block_exact(k);
    tick;
    checks++; if (out_ram_rd !== 1'b1 || out_ram_rd_addr !== 5'd17) begin
      failures++; $display("FAIL bp_rd17 got=rd%0b/addr%0d exp=rd1/addr17", out_ram_rd, out_ram_rd_addr);
    end
    recon_ready = 1'b0;
    tick;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++; if (res_valid !== 1'b1 || blk_idx !== 5'd17) begin
        failures++; $display("FAIL bp_hold c=%0d got=v%0b/idx%0d exp=v1/idx17", c, res_valid, blk_idx);
      end
      checks++; if (blk_is_chroma !== 1'b1 || blk_is_cr !== 1'b0) begin
        failures++; $display("FAIL bp_class got=ch%0b/cr%0b exp=ch1/cr0", blk_is_chroma, blk_is_cr);
      end
      checks++; if (out_ram_rd !== 1'b0) begin failures++; $display("FAIL bp_no_read got=%0b exp=0", out_ram_rd); end
    end
    recon_ready = 1'b1;
    tick;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", res_valid); end
    for (int k = 18; k < 24; k++) step_block_exact(k);
    tick;
  endtask

  task automatic test_abort;
    drive_idle;
    out_ram_wr_addr = 5'd24;
    pred_valid      = 1'b1;
    recon_ready     = 1'b1;
    start_mb(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step_block_exact(k);
    tick;
    tick;
    checks++; if (res_valid !== 1'b1 || blk_idx !== 5'd10) begin
      failures++; $display("FAIL abort_pre got=v%0b/idx%0d exp=v1/idx10", res_valid, blk_idx);
    end
    start_mb(1'b0, 1'b0);
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    checks++; if (out_ram_rd_addr !== 5'd0) begin failures++; $display("FAIL abort_addr got=%0d exp=0", out_ram_rd_addr); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL abort_rv got=%0b exp=0", res_valid); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (mb_rd_done !== 1'b0 || out_ram_rd !== 1'b0) begin
        failures++; $display("FAIL abort_quiet got=done%0b/rd%0b exp=done0/rd0", mb_rd_done, out_ram_rd);
      end
      tick;
    end
  endtask

  task automatic test_ena_freeze_and_async_reset;
    drive_idle;
    out_ram_wr_addr = 5'd24;
    pred_valid      = 1'b1;
    recon_ready     = 1'b0;
    start_mb(1'b1, 1'b0);
    tick;
    tick;
    ena         = 1'b0;
    recon_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (res_valid !== 1'b1 || blk_idx !== 5'd0 || out_ram_rd_addr !== 5'd1) begin
        failures++; $display("FAIL ena_freeze c=%0d got=v%0b/idx%0d/addr%0d exp=v1/idx0/addr1", c, res_valid, blk_idx, out_ram_rd_addr);
      end
      checks++; if (out_ram_rd !== 1'b0 || mb_rd_done !== 1'b0 || fsm_state !== ST_OUT) begin
        failures++; $display("FAIL ena_freeze_ctl got=rd%0b/done%0b/st%0d exp=rd0/done0/st%0d", out_ram_rd, mb_rd_done, fsm_state, ST_OUT);
      end
    end
    ena = 1'b1;
    tick;
    checks++; if (res_valid !== 1'b0 || fsm_state !== ST_WAIT) begin
      failures++; $display("FAIL ena_resume got=v%0b/st%0d exp=v0/st%0d", res_valid, fsm_state, ST_WAIT);
    end
    tick;
    tick;
    checks++; if (res_valid !== 1'b1 || blk_idx !== 5'd1) begin
      failures++; $display("FAIL arst_pre got=v%0b/idx%0d exp=v1/idx1", res_valid, blk_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_ram_rd, out_ram_rd_addr, res_valid, blk_idx, blk_is_chroma, blk_is_cr, mb_rd_done} !== 15'd0) begin
      failures++; $display("FAIL arst_outputs got=%h exp=0", {out_ram_rd, out_ram_rd_addr, res_valid, blk_idx, blk_is_chroma, blk_is_cr, mb_rd_done});
    end
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  // Random MB: random fill progress, pred_valid and recon_ready. The model
  // knows only the rules: blocks come in order 0..23, a read needs the block
  // filled and prediction ready, one block outstanding, data one cycle after
  // the read, and a done pulse right after the 24th transfer.
  task automatic test_random_mb(input int mb_n);
    int         wr_cnt;
    int         accepted;
    logic [4:0] pending;
    logic [4:0] exp_addr;
    bit         outstanding;
    bit         rd_prev;
    bit         acc;
    bit         pv_used;
    bit         done_seen;
    drive_idle;
    wr_cnt          = $urandom_range(0, 4);
    out_ram_wr_addr = 5'(wr_cnt);
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(5'(i));
    start_mb(1'b1, 1'b0);
    accepted = 0; outstanding = 0; rd_prev = 0; done_seen = 0; pending = '0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      if (wr_cnt < 24 && $urandom_range(0, 2) == 0) wr_cnt++;
      out_ram_wr_addr = 5'(wr_cnt);
      pred_valid      = ($urandom_range(0, 3) != 0);
      recon_ready     = $urandom_range(0, 1) == 1;
      pv_used         = pred_valid;
      acc             = (res_valid === 1'b1) && recon_ready;
      tick;
      if (acc) begin
        accepted++;
        outstanding = 0;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rnd_rv_clr mb=%0d got=%0b exp=0", mb_n, res_valid); end
      end
      if (out_ram_rd === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || outstanding || !pv_used) begin
          failures++; $display("FAIL rnd_extra_read mb=%0d got=addr%0d exp=no_read", mb_n, out_ram_rd_addr);
        end else begin
          exp_addr = exp_q.pop_front();
          checks++; if (out_ram_rd_addr !== exp_addr) begin failures++; $display("FAIL rnd_read_order mb=%0d got=%0d exp=%0d", mb_n, out_ram_rd_addr, exp_addr); end
          if (int'(out_ram_rd_addr) >= wr_cnt) begin
            failures++; $display("FAIL rnd_unfilled mb=%0d got=addr%0d exp=below%0d", mb_n, out_ram_rd_addr, wr_cnt);
          end
          pending     = exp_addr;
          outstanding = 1;
        end
      end
      if (rd_prev) begin
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rnd_latency mb=%0d got=%0b exp=1", mb_n, res_valid); end
      end
      if (res_valid === 1'b1) begin
        checks++; if (blk_idx !== pending || blk_is_chroma !== (pending >= 5'd16) || blk_is_cr !== (pending >= 5'd20)) begin
          failures++; $display("FAIL rnd_present mb=%0d got=%0d/%0b/%0b exp=%0d", mb_n, blk_idx, blk_is_chroma, blk_is_cr, pending);
        end
      end
      checks++; if (mb_rd_done !== (acc && accepted == 24)) begin
        failures++; $display("FAIL rnd_done mb=%0d got=%0b exp=%0b", mb_n, mb_rd_done, (acc && accepted == 24));
      end
      if (mb_rd_done === 1'b1) done_seen = 1;
      rd_prev = (out_ram_rd === 1'b1);
    end
    checks++; if (!done_seen || accepted != 24 || exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_complete mb=%0d got=acc%0d/left%0d exp=acc24/left0", mb_n, accepted, exp_q.size());
    end
    tick;
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL rnd_idle mb=%0d got=%0d exp=%0d", mb_n, fsm_state, ST_IDLE); end
  endtask

`ifdef RESIDUAL_RD_SKIP_EN
  task automatic test_skip_mb;
    int  hs_cnt;
    int  rd_cnt;
    int  done_cnt;
    int  tail;
    drive_idle;
    out_ram_wr_addr = 5'd0;
    recon_ready     = 1'b1;
    pred_valid      = 1'b1;
    start_mb(1'b1, 1'b1);
    hs_cnt = 0; rd_cnt = 0; done_cnt = 0; tail = 0;
    for (int c = 0; c < 400 && tail < 4; c++) begin
      pred_valid = ($urandom_range(0, 3) != 0);
      if (res_valid === 1'b1) begin
        hs_cnt++;
        checks++; if (res_zero !== 1'b1) begin failures++; $display("FAIL skip_res_zero got=%0b exp=1", res_zero); end
      end
      tick;
      if (out_ram_rd === 1'b1) rd_cnt++;
      if (mb_rd_done === 1'b1) done_cnt++;
      if (done_cnt > 0) tail++;
    end
    checks++; if (hs_cnt != 24) begin failures++; $display("FAIL skip_handshakes got=%0d exp=24", hs_cnt); end
    checks++; if (rd_cnt != 0) begin failures++; $display("FAIL skip_ram_reads got=%0d exp=0", rd_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL skip_done_count got=%0d exp=1", done_cnt); end
    checks++; if (res_zero !== 1'b1) begin failures++; $display("FAIL skip_zero_hold got=%0b exp=1", res_zero); end
    out_ram_wr_addr = 5'd24;
    start_mb(1'b1, 1'b0);
    checks++; if (res_zero !== 1'b0) begin failures++; $display("FAIL skip_zero_clear got=%0b exp=0", res_zero); end
    start_mb(1'b0, 1'b0);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_full_mb;
    test_writer_throttle;
    test_backpressure;
    test_abort;
    test_ena_freeze_and_async_reset;
    for (int m = 0; m < 6; m++) test_random_mb(m);
`ifdef RESIDUAL_RD_SKIP_EN
    test_skip_mb;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
